// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module      : instr_fetch_queue
// Description : Owns the fetch PC, reads word-addressed instruction memory and
//               buffers {pc, instr} pairs in a prefetch FIFO drained by decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_instr_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                instr_pc_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          not_empty;
    logic          pop;
    logic          push;

    assign not_empty = (count != '0);
    assign pop       = not_empty & instr_ready_i;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push      = ~redirect_i & ((count < CW'(DEPTH)) | pop);

    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = not_empty;
    assign instr_o       = not_empty ? instr_mem[rd_ptr] : 32'h0;
    assign instr_pc_o    = not_empty ? pc_mem[rd_ptr]    : 32'h0;
    assign count_o       = count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            // Redirect squashes everything, including a concurrent pop.
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; head outputs are masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_instr_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Scoreboard bench for instr_fetch_queue against a queue model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic [2:0]  count_o;

    int tests = 0;
    int fails = 0;

    entry_t      ref_q[$];
    entry_t      exp_q[$];
    logic [31:0] model_pc;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign imem_instr_i = mem_word(imem_addr_o);

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        exp_q.delete();
        model_pc = RESET_PC;
    endtask

    // Reference model: a plain list of fetched entries plus the next fetch address.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            model_reset();
        end else if (redirect_i) begin
            ref_q.delete();
            exp_q.delete();
            model_pc = {redirect_pc_i[31:2], 2'b00};
        end else begin
            entry_t e;
            if (ref_q.size() != 0 && instr_ready_i) void'(ref_q.pop_front());
            if (ref_q.size() < DEPTH) begin
                e.pc    = model_pc;
                e.instr = mem_word(model_pc);
                ref_q.push_back(e);
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
        end
    end

    // Monitor: occupancy/address every cycle, scoreboard pop on each accepted head.
    always @(negedge clk_i) begin
        chk("count", {29'd0, count_o}, ref_q.size());
        chk("valid", {31'd0, instr_valid_o}, {31'd0, ref_q.size() != 0});
        chk("imem_addr", imem_addr_o, model_pc);
        if (!instr_valid_o) begin
            chk("empty_instr", instr_o, 32'h0);
            chk("empty_pc", instr_pc_o, 32'h0);
        end else if (instr_ready_i && !redirect_i && rst_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", instr_pc_o, 32'hDEAD_DEAD);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("head_pc", instr_pc_o, e.pc);
                chk("head_instr", instr_o, e.instr);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        step(1);
        redirect_i    = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
        model_reset();
        step(2);
        rst_i = 1'b1;

        // Streaming at one per cycle, then fill and hold, then full pop+push.
        instr_ready_i = 1'b1;
        step(8);
        instr_ready_i = 1'b0;
        step(6);
        instr_ready_i = 1'b1;
        step(6);

        // Redirect with a partly filled queue and a concurrent pop.
        instr_ready_i = 1'b0;
        step(2);
        instr_ready_i = 1'b1;
        do_redirect(32'h0000_0043);
        step(3);

        // Address wrap at the top of the 32-bit space.
        do_redirect(32'hFFFF_FFF8);
        step(6);

        // Back-to-back redirects: last one wins.
        do_redirect(32'h0000_0100);
        do_redirect(32'h0000_0204);
        step(4);

        // Asynchronous reset mid-cycle with two entries held.
        instr_ready_i = 1'b0;
        do_redirect(32'h0000_0080);
        step(2);
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        chk("async_count", {29'd0, count_o}, 32'd0);
        chk("async_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("async_instr", instr_o, 32'h0);
        chk("async_pc", instr_pc_o, 32'h0);
        chk("async_addr", imem_addr_o, RESET_PC);
        step(2);
        rst_i         = 1'b1;
        instr_ready_i = 1'b1;
        step(4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = $urandom();
            step(1);
        end
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        step(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
